if_stage: RTL

Instruction-fetch stage and IF/ID pipeline register. It produces the `instruction`, `pc` and `pc_plus_4` values that the decode stage consumes. It runs a request/response handshake to instruction memory, keeps a small in-order fetch queue, and inserts NOP bubbles when no instruction is available. It honours the hazard unit's fetch stall and the execute stage's branch/jump redirect.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_queue.sv | 77 +++++++
 rtl/if_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the fetch stage and its queue.
//   XLEN          - architectural register / address width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0) used for pipeline bubbles
//   fetch_entry_t - one fetch-queue slot: request PC, returned word, filled flag
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order circular buffer of outstanding and returned fetches.
//   clk            - rising-edge clock
//   clear          - synchronous flush of every entry (reset / redirect)
//   alloc_en       - allocate a tail entry for an accepted request
//   alloc_pc       - PC stored in the new entry
//   fill_en        - a kept response is returned this cycle
//   fill_data      - instruction word written into the oldest unfilled entry
//   pop_en         - release the head entry
//   alloc_count    - entries allocated (in flight + filled)
//   unfilled_count - entries still waiting for their response
//   head           - oldest entry; meaningful only when alloc_count != 0
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     alloc_en,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill_en,
    input  logic [XLEN-1:0]          fill_data,
    input  logic                     pop_en,
    output logic [$clog2(DEPTH):0]   alloc_count,
    output logic [$clog2(DEPTH):0]   unfilled_count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t entries [DEPTH];
    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] pop_ptr;

    // Guard each action against its own occupancy so a stray response or a
    // pop on an empty queue cannot corrupt the pointers.
    logic do_alloc;
    logic do_fill;
    logic do_pop;

    assign do_alloc = alloc_en && (alloc_count != CW'(DEPTH));
    assign do_fill  = fill_en  && (unfilled_count != '0);
    assign do_pop   = pop_en   && (alloc_count != '0);

    assign head = entries[pop_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            alloc_ptr      <= '0;
            fill_ptr       <= '0;
            pop_ptr        <= '0;
            alloc_count    <= '0;
            unfilled_count <= '0;
        end else begin
            if (do_alloc) begin
                entries[alloc_ptr] <= '{pc: alloc_pc, data: '0, filled: 1'b0};
                alloc_ptr          <= alloc_ptr + 1'b1;
            end
            // Responses come back in order, so the oldest unfilled entry is
            // always the one at fill_ptr. It can coincide with a pop of the
            // same slot (bypass); the slot is then simply released.
            if (do_fill) begin
                entries[fill_ptr].data   <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + 1'b1;
            end
            if (do_pop) begin
                pop_ptr <= pop_ptr + 1'b1;
            end
            alloc_count    <= alloc_count + CW'(do_alloc) - CW'(do_pop);
            unfilled_count <= unfilled_count + CW'(do_alloc) - CW'(do_fill);
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch plus IF/ID pipeline register.
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   imem_req_*        - fetch request handshake (valid/ready, word address)
//   imem_resp_*       - in-order response (valid, instruction word)
//   stall_f           - hazard unit: hold IF/ID and keep the queue head
//   redirect_valid/pc - taken branch/jump from execute; flushes fetch
//   instruction, pc, pc_plus_4, instr_valid - IF/ID outputs (bubble = NOP/0/0/0)
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            stall_f,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            instr_valid
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   drop_count;
    logic [CW-1:0]   alloc_count;
    logic [CW-1:0]   unfilled_count;
    fetch_entry_t    head;

    logic            req_fire;
    logic            resp_live;
    logic            head_ready;
    logic [XLEN-1:0] head_data;
    logic            q_clear;
    logic            pop_en;

    // Target is always word aligned; the low bits carry no information.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req_valid = !reset && !redirect_valid && (alloc_count < CW'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response belongs to the live stream only when no stale responses
    // are still owed and some entry is waiting for it; anything else is
    // dropped (stale) or ignored (protocol error).
    assign resp_live  = imem_resp_valid && (drop_count == '0) && (unfilled_count != '0);

    // If the head is unfilled, an in-order live response is the head's data.
    assign head_ready = (alloc_count != '0) && (head.filled || resp_live);
    assign head_data  = head.filled ? head.data : imem_resp_data;

    assign q_clear = reset || redirect_valid;
    assign pop_en  = head_ready && !stall_f && !q_clear;

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk            (clk),
        .clear          (q_clear),
        .alloc_en       (req_fire),
        .alloc_pc       (fetch_pc),
        .fill_en        (resp_live),
        .fill_data      (imem_resp_data),
        .pop_en         (pop_en),
        .alloc_count    (alloc_count),
        .unfilled_count (unfilled_count),
        .head           (head)
    );

    // Fetch PC and stale-response accounting. On redirect every unfilled
    // entry still has a response in flight; one that lands in the redirect
    // cycle is discarded right away and so is not counted. Execute cannot
    // redirect again before the stale responses have drained, so the
    // outstanding drop_count is not carried across a second redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            drop_count <= '0;
        end else if (redirect_valid) begin
            fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
            drop_count <= unfilled_count - CW'(resp_live);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem_resp_valid && (drop_count != '0)) begin
                drop_count <= drop_count - 1'b1;
            end
        end
    end

    // IF/ID register: flush beats stall, stall beats advance.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            instruction <= NOP_INSTR;
            pc          <= '0;
            pc_plus_4   <= '0;
            instr_valid <= 1'b0;
        end else if (stall_f) begin
            instruction <= instruction;
            pc          <= pc;
            pc_plus_4   <= pc_plus_4;
            instr_valid <= instr_valid;
        end else if (head_ready) begin
            instruction <= head_data;
            pc          <= head.pc;
            pc_plus_4   <= head.pc + 32'd4;
            instr_valid <= 1'b1;
        end else begin
            instruction <= NOP_INSTR;
            pc          <= '0;
            pc_plus_4   <= '0;
            instr_valid <= 1'b0;
        end
    end

endmodule
